seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 14 +
 rtl/hex7seg.sv | 9 +
 rtl/seg_scan_ctrl.sv | 92 +++++++++
 tb/tb_seg_scan_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit seven-segment scanner.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;
  typedef enum logic {S_SHOW = 1'b0, S_DEAD = 1'b1} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Entry n is the glyph for hex digit n (listed F down to 0).
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_FONT[nibble];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner with dead time between digits
// and frame-aligned, tear-free shadow loading of the displayed value.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  blank_in,
  input  logic        load_req,
  output logic        load_ack,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);
  localparam int CMAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    idx, idx_d;
  logic [15:0]   shadow_val;
  logic [3:0]    shadow_blank;
  logic          boundary, capture;
  logic [3:0]    an_d;
  logic [6:0]    seg_d, dec_seg;

  hex7seg u_dec (
    .nibble (shadow_val[{idx, 2'b00} +: 4]),
    .seg    (dec_seg)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt + 1'b1;
    idx_d    = idx;
    boundary = 1'b0;
    an_d     = AN_OFF;
    seg_d    = SEG_BLANK;
    if (state == S_SHOW) begin
      if (cnt == SHOW_LAST) begin
        state_d = S_DEAD;
        cnt_d   = '0;
      end
      if (!shadow_blank[idx]) begin
        an_d[idx] = 1'b0;
        seg_d     = dec_seg;
      end
    end else if (cnt == DEAD_LAST) begin
      state_d  = S_SHOW;
      cnt_d    = '0;
      idx_d    = idx + 2'd1;
      boundary = (idx == 2'd3);
    end
  end

  // Shadow only moves at the digit3 -> digit0 boundary, so a frame never mixes values.
  assign capture = boundary && load_req;
  assign dp      = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_DEAD;
      cnt          <= '0;
      idx          <= 2'd3;
      shadow_val   <= 16'h0000;
      shadow_blank <= 4'hF;
      an           <= AN_OFF;
      seg          <= SEG_BLANK;
      load_ack     <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      an         <= an_d;
      seg        <= seg_d;
      load_ack   <= capture;
      frame_tick <= boundary;
      if (capture) begin
        shadow_val   <= value_in;
        shadow_blank <= blank_in;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed, table-driven bench for seg_scan_ctrl with SCAN_DIV=4, DEAD_CYC=2.
module tb_seg_scan_ctrl;
  localparam int SD = 4, DC = 2, SLOT = SD + DC, FRAME = 4 * SLOT;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load_req = 1'b0;
  logic        load_ack, dp, frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg;

  int vecs = 0, errs = 0, multi_low = 0;

  seg_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYC(DC)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .blank_in(blank_in),
    .load_req(load_req), .load_ack(load_ack), .an(an), .seg(seg),
    .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && $countones(~an) > 1) multi_low++;

  typedef struct {
    logic [15:0]      val;
    logic [3:0]       blk;
    logic [3:0][6:0]  segs;  // {digit3, digit2, digit1, digit0}
    logic [3:0][3:0]  ans;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ack(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (load_ack) begin cyc = i; break; end
    end
  endtask

  task automatic wait_tick(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (frame_tick) begin cyc = i; break; end
    end
  endtask

  // Called on the negedge where ack/tick is seen; checks every slot of the next frame.
  task automatic observe_frame(input int v);
    int pos = 0;
    for (int k = 0; k < 4; k++) begin
      repeat (SLOT * k + 2 - pos) @(negedge clk);
      chk($sformatf("v%0d_d%0d_an", v, k), {28'd0, an}, {28'd0, vt[v].ans[k]});
      chk($sformatf("v%0d_d%0d_seg", v, k), {25'd0, seg}, {25'd0, vt[v].segs[k]});
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_d%0d_dead_an", v, k), {28'd0, an}, 32'hF);
      pos = SLOT * k + 5;
    end
  endtask

  initial begin
    int cyc, acks;
    vt[0] = '{16'h1234, 4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vt[1] = '{16'hABCD, 4'h0, {7'h08, 7'h03, 7'h46, 7'h21}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vt[2] = '{16'h0000, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, {4'hF, 4'hF, 4'hF, 4'hF}};
    vt[3] = '{16'h5678, 4'hA, {7'h7F, 7'h02, 7'h7F, 7'h00}, {4'hF, 4'hB, 4'hF, 4'hE}};
    vt[4] = '{16'h9EF0, 4'h0, {7'h10, 7'h06, 7'h0E, 7'h40}, {4'h7, 4'hB, 4'hD, 4'hE}};

    // Reset values, with a load request held through reset.
    load_req = 1'b1; value_in = vt[0].val; blank_in = vt[0].blk;
    repeat (3) @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp_ack_tick", {29'd0, dp, load_ack, frame_tick}, 32'h4);
    rst_n = 1'b1;

    // Table: load each vector at a boundary and check the following frame.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        load_req = 1'b1; value_in = vt[i].val; blank_in = vt[i].blk;
      end
      wait_ack(FRAME + 2, cyc);
      if (i == 0) begin
        chk("first_ack_latency", cyc, 2);
        chk("first_tick_with_ack", {31'd0, frame_tick}, 32'd1);
      end else begin
        chk($sformatf("v%0d_ack_seen", i), {31'd0, cyc > 0}, 32'd1);
      end
      load_req = 1'b0;
      if (cyc > 0) observe_frame(i);
    end

    // Free run: frame_tick period, no acks without a request.
    wait_tick(FRAME + 2, cyc);
    chk("tick_found", {31'd0, cyc > 0}, 32'd1);
    acks = 0;
    for (int f = 0; f < 2; f++) begin
      cyc = -1;
      for (int i = 1; i <= FRAME + 4; i++) begin
        @(negedge clk);
        if (load_ack) acks++;
        if (frame_tick) begin cyc = i; break; end
      end
      chk($sformatf("tick_period_%0d", f), cyc, FRAME);
    end
    chk("idle_no_ack", acks, 0);

    // Mid-frame request: display keeps old shadow until the boundary, one ack.
    repeat (7) @(negedge clk);
    load_req = 1'b1; value_in = vt[1].val; blank_in = vt[1].blk;
    @(negedge clk);
    chk("midframe_seg_hold", {25'd0, seg}, 32'h0E);
    wait_ack(FRAME + 2, cyc);
    chk("midframe_ack_latency", cyc, 16);
    load_req = 1'b0;
    if (cyc > 0) observe_frame(1);
    acks = 0;
    repeat (FRAME + 2) begin
      @(negedge clk);
      if (load_ack) acks++;
    end
    chk("midframe_single_ack", acks, 0);

    // Request held after ack counts as a new request at the next boundary.
    load_req = 1'b1; value_in = vt[0].val; blank_in = vt[0].blk;
    wait_ack(FRAME + 2, cyc);
    chk("held_ack1_latency", cyc, 23);
    @(negedge clk);
    chk("held_ack_one_cycle", {31'd0, load_ack}, 32'd0);
    wait_ack(FRAME + 2, cyc);
    chk("held_ack2_spacing", cyc, FRAME - 1);
    load_req = 1'b0;

    // One-cycle pulse mid-frame: no capture, no ack.
    repeat (5) @(negedge clk);
    load_req = 1'b1; value_in = 16'hFFFF; blank_in = 4'h0;
    @(negedge clk);
    load_req = 1'b0;
    wait_ack(FRAME + 6, cyc);
    chk("pulse_no_ack", cyc, -1);
    wait_tick(FRAME + 2, cyc);
    if (cyc > 0) observe_frame(0);
    else chk("pulse_tick_found", cyc, 1);

    // Async reset during the digit2 show slot, then restart.
    repeat (15) @(negedge clk);
    chk("pre_rst_an_digit2", {28'd0, an}, 32'hB);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_an", {28'd0, an}, 32'hF);
    chk("async_rst_seg", {25'd0, seg}, 32'h7F);
    chk("async_rst_ack_tick", {30'd0, load_ack, frame_tick}, 32'd0);
    @(negedge clk);
    load_req = 1'b1; value_in = vt[1].val; blank_in = vt[1].blk;
    rst_n = 1'b1;
    wait_ack(FRAME, cyc);
    chk("restart_ack_latency", cyc, 2);
    load_req = 1'b0;
    if (cyc > 0) observe_frame(1);

    chk("never_two_an_low", multi_low, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
